// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with tick prescaler, load, wrap/saturate and seven-segment decode.
// Optional leading-zero blanking on the hex outputs when BCD_CNT_LZB_EN is defined.
module bcd_updown_counter_n #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  sat,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  tick,
  output logic                  tc
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       r_presc;
  logic [4*DIGITS-1:0] r_bcd;
  logic                r_tc;

  logic [4*DIGITS-1:0] w_inc;
  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_load_clamped;
  logic [DIGITS:0]     w_carry;
  logic [DIGITS:0]     w_borrow;
  logic                w_wrap;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

`ifdef BCD_CNT_LZB_EN
  // w_zero_hi[i]: digit i and every digit above it are zero
  logic [DIGITS:1] w_zero_hi;
  assign w_zero_hi[DIGITS] = 1'b1;
`endif

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] w_d;
      logic [3:0] w_ld;
      assign w_d  = r_bcd[4*gi +: 4];
      assign w_ld = load_val[4*gi +: 4];

      assign w_inc[4*gi +: 4]  = !w_carry[gi]  ? w_d : ((w_d == 4'd9) ? 4'd0 : w_d + 4'd1);
      assign w_carry[gi+1]     = w_carry[gi] && (w_d == 4'd9);
      assign w_dec[4*gi +: 4]  = !w_borrow[gi] ? w_d : ((w_d == 4'd0) ? 4'd9 : w_d - 4'd1);
      assign w_borrow[gi+1]    = w_borrow[gi] && (w_d == 4'd0);

      assign w_load_clamped[4*gi +: 4] = (w_ld > 4'd9) ? 4'd9 : w_ld;

`ifdef BCD_CNT_LZB_EN
      if (gi == 0) begin : g_lsd
        assign hex[7*gi +: 7] = seg7(w_d);
      end else begin : g_upper
        if (gi < DIGITS - 1) begin : g_mid
          assign w_zero_hi[gi] = (w_d == 4'd0) && w_zero_hi[gi+1];
        end else begin : g_top
          assign w_zero_hi[gi] = (w_d == 4'd0);
        end
        assign hex[7*gi +: 7] = w_zero_hi[gi] ? 7'b1111111 : seg7(w_d);
      end
`else
      assign hex[7*gi +: 7] = seg7(w_d);
`endif
    end
  endgenerate

  // Boundary reached: all-9s going up or all-0s going down
  assign w_wrap = up ? w_carry[DIGITS] : w_borrow[DIGITS];
  assign tick   = (r_presc == PRESC_LAST);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_bcd   <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_bcd   <= w_load_clamped;
        r_presc <= '0;
      end else begin
        r_presc <= tick ? '0 : r_presc + 1'b1;
        if (tick && enable) begin
          r_tc <= w_wrap;
          if (!(sat && w_wrap))
            r_bcd <= up ? w_inc : w_dec;
        end
      end
    end
  end

  assign bcd = r_bcd;
  assign tc  = r_tc;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench for bcd_updown_counter_n with DIGITS=2, TICK_DIV=4; all timing counted in cycles.
module tb_bcd_updown_counter_n;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        enable   = 1'b0;
  logic        up       = 1'b1;
  logic        sat      = 1'b0;
  logic        load     = 1'b0;
  logic [7:0]  load_val = 8'h00;
  logic [7:0]  bcd;
  logic [13:0] hex;
  logic        tick;
  logic        tc;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0010000, SB = 7'b1111111;

`ifdef BCD_CNT_LZB_EN
  localparam logic [13:0] HEX_ZERO = {SB, S0};
`else
  localparam logic [13:0] HEX_ZERO = {S0, S0};
`endif

  bcd_updown_counter_n #(.DIGITS(2), .TICK_DIV(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .hex      (hex),
    .tick     (tick),
    .tc       (tc)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    cyc(1);
    load     = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    cyc(2);
    check("rst_bcd", 32'(bcd), 32'h00);
    check("rst_tc", 32'(tc), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_hex", 32'(hex), 32'(HEX_ZERO));

    // release; prescaler 0 -> tick visible after 3 edges, step on 4th
    reset = 1'b1; enable = 1'b1; up = 1'b1; sat = 1'b0;
    cyc(1); check("tick_p1", 32'(tick), 32'h0);
    cyc(1); check("tick_p2", 32'(tick), 32'h0);
    cyc(1); check("tick_p3", 32'(tick), 32'h1);
    check("bcd_pre_step", 32'(bcd), 32'h00);
    cyc(1); check("bcd_step1", 32'(bcd), 32'h01);
    check("tick_after_step", 32'(tick), 32'h0);
    cyc(36);
    check("bcd_10", 32'(bcd), 32'h10);
    check("hex_10", 32'(hex), 32'({S1, S0}));

    // load 98, up wrap
    do_load(8'h98);
    check("ld98_bcd", 32'(bcd), 32'h98);
    check("ld98_hex", 32'(hex), 32'({S9, S8}));
    check("ld98_tc", 32'(tc), 32'h0);
    cyc(4); check("up_99", 32'(bcd), 32'h99);
    check("up_99_tc", 32'(tc), 32'h0);
    cyc(3); check("pre_wrap_tc", 32'(tc), 32'h0);
    cyc(1); check("wrap_00", 32'(bcd), 32'h00);
    check("wrap_tc", 32'(tc), 32'h1);
    cyc(1); check("wrap_tc_end", 32'(tc), 32'h0);

    // load 01 down saturate (prescaler at 1)
    up = 1'b0; sat = 1'b1;
    do_load(8'h01);
    check("ld01_bcd", 32'(bcd), 32'h01);
    cyc(4); check("dn_00", 32'(bcd), 32'h00);
    check("dn_00_tc", 32'(tc), 32'h0);
    cyc(4); check("sat_dn_bcd2", 32'(bcd), 32'h00);
    check("sat_dn_tc2", 32'(tc), 32'h1);
    cyc(1); check("sat_dn_tc2_end", 32'(tc), 32'h0);
    cyc(3); check("sat_dn_bcd3", 32'(bcd), 32'h00);
    check("sat_dn_tc3", 32'(tc), 32'h1);
    cyc(1); check("sat_dn_tc3_end", 32'(tc), 32'h0);

    // invalid digits clamp, load coincident with tick (prescaler at 1)
    up = 1'b1; sat = 1'b1;
    cyc(2); check("tick_before_ld", 32'(tick), 32'h1);
    do_load(8'hFA);
    check("ldFA_bcd", 32'(bcd), 32'h99);
    check("ldFA_tc", 32'(tc), 32'h0);
    check("ldFA_tick", 32'(tick), 32'h0);
    cyc(2); check("ldFA_tick_p2", 32'(tick), 32'h0);
    cyc(1); check("ldFA_tick_p3", 32'(tick), 32'h1);
    cyc(1); check("sat_up_bcd", 32'(bcd), 32'h99);
    check("sat_up_tc", 32'(tc), 32'h1);
    cyc(1); check("sat_up_tc_end", 32'(tc), 32'h0);

    // down wrap from 00 (prescaler at 1)
    up = 1'b0; sat = 1'b0;
    do_load(8'h00);
    cyc(4); check("dn_wrap_bcd", 32'(bcd), 32'h99);
    check("dn_wrap_tc", 32'(tc), 32'h1);
    cyc(1); check("dn_wrap_tc_end", 32'(tc), 32'h0);

    // enable=0 hold at 42, then re-enable right after a tick
    up = 1'b1;
    do_load(8'h42);
    enable = 1'b0;
    check("ld42_hex", 32'(hex), 32'({S4, S2}));
    cyc(12); check("hold_42", 32'(bcd), 32'h42);
    enable = 1'b1;
    cyc(3); check("reen_no_step", 32'(bcd), 32'h42);
    check("reen_tick", 32'(tick), 32'h1);
    cyc(1); check("reen_step", 32'(bcd), 32'h43);

    // async reset mid-count at 57
    do_load(8'h57);
    check("ld57_hex", 32'(hex), 32'({S5, S7}));
    cyc(2);
    #2 reset = 1'b0;
    #1 check("rst57_bcd", 32'(bcd), 32'h00);
    check("rst57_hex", 32'(hex), 32'(HEX_ZERO));
    cyc(1); reset = 1'b1;

    // async reset during a tc pulse
    do_load(8'h99);
    cyc(4); check("tc_before_rst", 32'(tc), 32'h1);
    #2 reset = 1'b0;
    #1 check("rst_tc_clear", 32'(tc), 32'h0);
    check("rst_tc_bcd", 32'(bcd), 32'h00);
    cyc(2); check("rst_hold_tc", 32'(tc), 32'h0);
    check("rst_hold_tick", 32'(tick), 32'h0);
    reset = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
